// File: rtl/iob_regfile_sp_pkg.sv
// rtl/iob_regfile_sp_pkg.sv - shared state encoding and width helpers for the regfile reader
package iob_regfile_sp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int ADDR_W_DEFAULT = 2;
    localparam int CNT_W          = ADDR_W_DEFAULT + 1;

    // Remaining-count width: one extra bit so a command may cover more than the whole file.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/iob_regfile_sp_rd_stage.sv
// rtl/iob_regfile_sp_rd_stage.sv - one-entry valid/ready output register with load/consume control
module iob_regfile_sp_rd_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              consume_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              m_valid_o
);

    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              valid_q;

    // A load always wins: the controller only loads when the held word is absent or leaving.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            last_q  <= last_i;
            valid_q <= 1'b1;
        end else if (consume_i) begin
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end
    end

    assign m_data_o  = data_q;
    assign m_last_o  = last_q;
    assign m_valid_o = valid_q;

endmodule

// File: rtl/iob_regfile_sp_reader.sv
// rtl/iob_regfile_sp_reader.sv - streams a wrapping address range of a single-port regfile out on valid/ready
module iob_regfile_sp_reader
    import iob_regfile_sp_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_w_data,
    input  logic [DATA_W-1:0] rf_r_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int CW = cnt_w(ADDR_W);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic              done_q, done_d;
    logic              load;
    logic              consume;
    logic              last_word;

    assign last_word = (rem_q == CW'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        load    = 1'b0;
        consume = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d  = first_addr;
                        rem_d   = count;
                        state_d = ST_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // Loading whenever the output slot is empty or draining keeps the stream bubble-free.
                if ((!m_valid || m_ready) && rem_q != '0) begin
                    load   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - CW'(1);
                    if (last_word) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (m_valid && m_ready) begin
                    consume = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    iob_regfile_sp_rd_stage #(
        .DATA_W (DATA_W)
    ) u_rd_stage (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .data_i    (rf_r_data),
        .last_i    (last_word),
        .consume_i (consume),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign rf_we     = 1'b0;
    assign rf_w_data = '0;
    assign rf_addr   = addr_q;

endmodule

// File: tb/tb_iob_regfile_sp_reader.sv
// tb/tb_iob_regfile_sp_reader.sv - scoreboard bench for the regfile stream reader
module tb_iob_regfile_sp_reader;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [31:0] cyc;
    } word_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  first_addr;
    logic [2:0]  count;
    logic        busy;
    logic        done;
    logic        rf_we;
    logic [1:0]  rf_addr;
    logic [31:0] rf_w_data;
    logic [31:0] rf_r_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    logic [31:0] rf_mem [4];
    logic [31:0] cyc = 0;
    logic [31:0] start_cyc;
    logic        side_bad = 1'b0;

    word_t       got_q[$];
    exp_t        exp_q[$];
    logic [31:0] done_log[$];

    int total = 0;
    int bad   = 0;

    iob_regfile_sp_reader #(
        .ADDR_W (2),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_w_data  (rf_w_data),
        .rf_r_data  (rf_r_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    assign rf_r_data = rf_mem[rf_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observes the DUT between edges; only records, the test tasks do the comparing.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back('{data: m_data, last: m_last, cyc: cyc});
        if (!rst && done) done_log.push_back(cyc);
        if (rf_we !== 1'b0 || rf_w_data !== 32'h0 || (done && busy)) side_bad = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        done_log.delete();
    endtask

    task automatic start_cmd(input logic [1:0] fa, input logic [2:0] cnt);
        first_addr = fa;
        count      = cnt;
        start      = 1'b1;
        start_cyc  = cyc;
        for (int i = 0; i < int'(cnt); i++)
            exp_q.push_back('{data: rf_mem[(int'(fa) + i) % 4], last: (i == int'(cnt) - 1)});
        step();
        start = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, output logic ok);
        for (int b = 0; b < budget && got_q.size() < n; b++) step();
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        first_addr = 2'd0;
        count = 3'd0;
        m_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        total++;
        if ({busy, done, m_valid, m_last, rf_we} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, m_valid, m_last, rf_we});
        end
        total++;
        if (m_data !== 32'h0 || rf_addr !== 2'd0 || rf_w_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got data=%h addr=%0d wdata=%h want 0", m_data, rf_addr, rf_w_data);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic ok;
        logic [31:0] last_cyc;
        clear_logs();
        start_cmd(2'd1, 3'd3);
        wait_words(3, 30, ok);
        repeat (3) step();
        total++;
        if (!ok || got_q.size() != 3) begin
            bad++;
            $display("FAIL basic_count: got %0d words want 3", got_q.size());
        end
        for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
            word_t g = got_q.pop_front();
            exp_t  e = exp_q.pop_front();
            total++;
            if (g.data !== e.data || g.last !== e.last) begin
                bad++;
                $display("FAIL basic_word[%0d]: got %h/%b want %h/%b", i, g.data, g.last, e.data, e.last);
            end
            total++;
            if (g.cyc !== start_cyc + 2 + i) begin
                bad++;
                $display("FAIL basic_timing[%0d]: got cycle %0d want %0d", i, g.cyc, start_cyc + 2 + i);
            end
            last_cyc = g.cyc;
        end
        total++;
        if (done_log.size() != 1 || done_log[0] !== last_cyc + 1) begin
            bad++;
            $display("FAIL basic_done: got %0d pulses want 1 at cycle %0d", done_log.size(), last_cyc + 1);
        end
    endtask

    task automatic test_wrap();
        logic ok;
        for (int c = 0; c < 2; c++) begin
            clear_logs();
            if (c == 0) start_cmd(2'd3, 3'd3);
            else        start_cmd(2'd0, 3'd6);
            wait_words(exp_q.size(), 40, ok);
            repeat (3) step();
            total++;
            if (!ok || got_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL wrap_count[%0d]: got %0d words want %0d", c, got_q.size(), exp_q.size());
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                word_t g = got_q.pop_front();
                exp_t  e = exp_q.pop_front();
                total++;
                if (g.data !== e.data || g.last !== e.last) begin
                    bad++;
                    $display("FAIL wrap_word[%0d]: got %h/%b want %h/%b", c, g.data, g.last, e.data, e.last);
                end
            end
            total++;
            if (done_log.size() != 1) begin
                bad++;
                $display("FAIL wrap_done[%0d]: got %0d pulses want 1", c, done_log.size());
            end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        clear_logs();
        m_ready = 1'b0;
        start_cmd(2'd0, 3'd4);
        for (int b = 0; b < 20 && !m_valid; b++) step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (m_valid !== 1'b1 || m_data !== 32'h11 || m_last !== 1'b0 || rf_addr !== 2'd1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b a=%0d want 1/11/0/1", i, m_valid, m_data, m_last, rf_addr);
            end
            step();
        end
        m_ready = 1'b1;
        wait_words(4, 30, ok);
        repeat (4) step();
        total++;
        if (!ok || got_q.size() != 4) begin
            bad++;
            $display("FAIL bp_count: got %0d words want 4", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            word_t g = got_q.pop_front();
            exp_t  e = exp_q.pop_front();
            total++;
            if (g.data !== e.data || g.last !== e.last) begin
                bad++;
                $display("FAIL bp_word: got %h/%b want %h/%b", g.data, g.last, e.data, e.last);
            end
        end
        total++;
        if (done_log.size() != 1) begin
            bad++;
            $display("FAIL bp_done: got %0d pulses want 1", done_log.size());
        end
    endtask

    task automatic test_zero_count();
        logic seen = 1'b0;
        clear_logs();
        start_cmd(2'd2, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || m_valid !== 1'b0) seen = 1'b1;
            step();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL zero_busy: got busy/valid high want both low");
        end
        total++;
        if (done_log.size() != 1 || done_log[0] !== start_cyc + 1) begin
            bad++;
            $display("FAIL zero_done: got %0d pulses want 1 at cycle %0d", done_log.size(), start_cyc + 1);
        end
    endtask

    task automatic test_start_while_busy();
        logic ok;
        clear_logs();
        start_cmd(2'd0, 3'd4);
        step();
        first_addr = 2'd2;
        count = 3'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_words(4, 30, ok);
        repeat (5) step();
        total++;
        if (!ok || got_q.size() != 4) begin
            bad++;
            $display("FAIL busy_start_count: got %0d words want 4", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            word_t g = got_q.pop_front();
            exp_t  e = exp_q.pop_front();
            total++;
            if (g.data !== e.data || g.last !== e.last) begin
                bad++;
                $display("FAIL busy_start_word: got %h/%b want %h/%b", g.data, g.last, e.data, e.last);
            end
        end
        total++;
        if (done_log.size() != 1) begin
            bad++;
            $display("FAIL busy_start_done: got %0d pulses want 1", done_log.size());
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        clear_logs();
        start_cmd(2'd0, 3'd4);
        wait_words(2, 30, ok);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: got v=%b busy=%b done=%b want 000", m_valid, busy, done);
        end
        repeat (5) step();
        total++;
        if (!ok || got_q.size() != 2 || done_log.size() != 0) begin
            bad++;
            $display("FAIL midrst_abort: got %0d words %0d dones want 2 words 0 dones", got_q.size(), done_log.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            word_t g = got_q.pop_front();
            exp_t  e = exp_q.pop_front();
            total++;
            if (g.data !== e.data || g.last !== e.last) begin
                bad++;
                $display("FAIL midrst_word: got %h/%b want %h/%b", g.data, g.last, e.data, e.last);
            end
        end
        clear_logs();
        start_cmd(2'd2, 3'd2);
        wait_words(2, 30, ok);
        repeat (3) step();
        total++;
        if (!ok || got_q.size() != 2 || done_log.size() != 1) begin
            bad++;
            $display("FAIL midrst_restart: got %0d words %0d dones want 2 and 1", got_q.size(), done_log.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            word_t g = got_q.pop_front();
            exp_t  e = exp_q.pop_front();
            total++;
            if (g.data !== e.data || g.last !== e.last) begin
                bad++;
                $display("FAIL midrst_restart_word: got %h/%b want %h/%b", g.data, g.last, e.data, e.last);
            end
        end
    endtask

    initial begin
        rf_mem[0] = 32'h11;
        rf_mem[1] = 32'h22;
        rf_mem[2] = 32'h33;
        rf_mem[3] = 32'h44;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_start_while_busy();
        test_reset_mid();
        total++;
        if (side_bad) begin
            bad++;
            $display("FAIL side_outputs: got write/done-with-busy activity want none");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
